datapath_sequencer: RTL



---
 rtl/datapath_sequencer_if.sv | 37 +++
 rtl/datapath_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/datapath_sequencer_if.sv
// Instruction handshake plus execute-datapath control bundle between the
// instruction source, the sequencer and the register-file/ALU datapath.
interface datapath_sequencer_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    logic                     instr_valid;
    logic [DATA_WIDTH-1:0]    instr;
    logic                     instr_ready;
    logic                     eq;
    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    ImmOp;
    logic                     ALUSrc;
    logic                     ALU_ctrl;
    logic                     regFileWen;
    logic                     branch_valid;
    logic                     branch_taken;
    logic [DATA_WIDTH-1:0]    branch_offset;
    logic                     illegal;
    logic [15:0]              retired_count;

    // Instruction source / datapath side
    modport master (
        output instr_valid, instr, eq,
        input  instr_ready, rs1, rs2, rd, ImmOp, ALUSrc, ALU_ctrl, regFileWen,
               branch_valid, branch_taken, branch_offset, illegal, retired_count
    );

    // Sequencer side
    modport slave (
        input  instr_valid, instr, eq,
        output instr_ready, rs1, rs2, rd, ImmOp, ALUSrc, ALU_ctrl, regFileWen,
               branch_valid, branch_taken, branch_offset, illegal, retired_count
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Three-state (IDLE/EXEC/WB) control sequencer for ADD, ADDI and BNE on the
// execute datapath; one instruction in flight, retire counter and branch report.
module datapath_sequencer #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    datapath_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_q;
    logic                  eq_q;
    logic [15:0]           retired_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_add, is_addi, is_bne, legal, busy;

    function automatic logic signed [DATA_WIDTH-1:0] sext_i(input logic [DATA_WIDTH-1:0] w);
        return {{(DATA_WIDTH-12){w[31]}}, w[31:20]};
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sext_b(input logic [DATA_WIDTH-1:0] w);
        return {{(DATA_WIDTH-13){w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    assign opcode  = instr_q[6:0];
    assign funct3  = instr_q[14:12];
    assign funct7  = instr_q[31:25];
    assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
    assign legal   = is_add || is_addi || is_bne;
    assign busy    = (state_q == EXEC) || (state_q == WB);

    // State, latched word, registered eq flag and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            eq_q      <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.instr_valid)
                instr_q <= bus.instr;
            if (state_q == EXEC)
                eq_q <= bus.eq;
            if (state_q == WB && legal)
                retired_q <= retired_q + 16'd1;
        end
    end

    // Next state and datapath controls
    always_comb begin
        state_d            = state_q;
        bus.instr_ready    = 1'b0;
        bus.rs1            = '0;
        bus.rs2            = '0;
        bus.rd             = '0;
        bus.ImmOp          = '0;
        bus.ALUSrc         = 1'b0;
        bus.ALU_ctrl       = 1'b0;
        bus.regFileWen     = 1'b0;
        bus.branch_valid   = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.branch_offset  = '0;
        bus.illegal        = 1'b0;

        case (state_q)
            IDLE: begin
                bus.instr_ready = rst_n;
                if (bus.instr_valid)
                    state_d = EXEC;
            end
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Illegal words leave every control at 0 and only raise the WB pulse
        if (busy && legal) begin
            bus.rs1      = instr_q[19:15];
            bus.rs2      = instr_q[24:20];
            bus.rd       = instr_q[11:7];
            bus.ALUSrc   = is_addi;
            bus.ALU_ctrl = is_bne;
            if (is_addi)
                bus.ImmOp = sext_i(instr_q);
            else if (is_bne)
                bus.ImmOp = sext_b(instr_q);
            if (is_bne)
                bus.branch_offset = sext_b(instr_q);
        end

        if (state_q == WB) begin
            bus.regFileWen   = (is_add || is_addi) && (instr_q[11:7] != '0);
            bus.branch_valid = is_bne;
            bus.branch_taken = is_bne && !eq_q;
            bus.illegal      = !legal;
        end
    end

    assign bus.retired_count = retired_q;
endmodule
